// File: rtl/mips_pkg.sv
// Shared datapath types for the writeback, register file and hazard units.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int REG_ZERO = 0;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        word_t    pc;
        reg_idx_t idx;
        word_t    data;
    } wb_log_t;

    function automatic logic isZeroIdx(input reg_idx_t idx);
        return idx == reg_idx_t'(REG_ZERO);
    endfunction

endpackage

// File: rtl/grf_commit_log.sv
// Registered commit-log record and running count of emitted records.
module grf_commit_log #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              logEn,
    input  logic [31:0]       pc,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] data,
    output logic              log_valid,
    output logic [31:0]       log_pc,
    output logic [ADDR_W-1:0] log_reg,
    output logic [DATA_W-1:0] log_data,
    output logic [31:0]       wr_count
);

    logic              validQ;
    logic [31:0]       pcQ;
    logic [ADDR_W-1:0] idxQ;
    logic [DATA_W-1:0] dataQ;
    logic [31:0]       wrCountQ;

    // Fields only load on a record so they hold between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            validQ   <= 1'b0;
            pcQ      <= '0;
            idxQ     <= '0;
            dataQ    <= '0;
            wrCountQ <= '0;
        end else begin
            validQ <= logEn;
            if (logEn) begin
                pcQ      <= pc;
                idxQ     <= idx;
                dataQ    <= data;
                wrCountQ <= wrCountQ + 32'd1;
            end
        end
    end

    assign log_valid = validQ;
    assign log_pc    = pcQ;
    assign log_reg   = idxQ;
    assign log_data  = dataQ;
    assign wr_count  = wrCountQ;

endmodule

// File: rtl/grf.sv
// General register file: two combinational read ports, one write port, commit log.
// Define GRF_BYPASS_EN for same-cycle write-through on the read ports.
module grf
    import mips_pkg::*;
#(
    parameter int DATA_W          = mips_pkg::DATA_W,
    parameter int ADDR_W          = mips_pkg::ADDR_W,
    parameter int LOG_ZERO_WRITES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteW,
    input  logic [ADDR_W-1:0] WriteRegW,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [31:0]       PC_W,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              log_valid,
    output logic [31:0]       log_pc,
    output logic [ADDR_W-1:0] log_reg,
    output logic [DATA_W-1:0] log_data,
    output logic [31:0]       wr_count
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NREG];
    logic              wrNonZero;
    logic              logEn;

    assign wrNonZero = RegWriteW && (WriteRegW != ZERO_IDX);
    assign logEn     = wrNonZero ||
                       (RegWriteW && (LOG_ZERO_WRITES != 0));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wrNonZero) begin
            regs[WriteRegW] <= ResultW;
        end
    end

    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (A1 != ZERO_IDX) begin
            RD1 = regs[A1];
`ifdef GRF_BYPASS_EN
            if (wrNonZero && (WriteRegW == A1)) begin
                RD1 = ResultW;
            end
`endif
        end
        if (A2 != ZERO_IDX) begin
            RD2 = regs[A2];
`ifdef GRF_BYPASS_EN
            if (wrNonZero && (WriteRegW == A2)) begin
                RD2 = ResultW;
            end
`endif
        end
    end

    grf_commit_log #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) uLog (
        .clk      (clk),
        .reset    (reset),
        .logEn    (logEn),
        .pc       (PC_W),
        .idx      (WriteRegW),
        .data     (ResultW),
        .log_valid(log_valid),
        .log_pc   (log_pc),
        .log_reg  (log_reg),
        .log_data (log_data),
        .wr_count (wr_count)
    );

endmodule
